// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of a dual-port RAM's read and write ports between two masters
module ram_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);
    logic wr_last, rd_last, rsp_v, rsp_id;
    logic m0_w, m1_w, m0_r, m1_r, w_sel, r_sel, w_go, r_go;
    assign m0_w = m0_req & m0_we;
    assign m1_w = m1_req & m1_we;
    assign m0_r = m0_req & ~m0_we;
    assign m1_r = m1_req & ~m1_we;
    // a sel bit of 1 picks master 1: alone, or contending with master 0 granted last
    assign w_sel = m1_w & (~m0_w | ~wr_last);
    assign r_sel = m1_r & (~m0_r | ~rd_last);
    assign w_go = rst & (m0_w | m1_w);
    assign r_go = rst & (m0_r | m1_r);
    assign m0_gnt = rst & ((m0_w & ~w_sel) | (m0_r & ~r_sel));
    assign m1_gnt = rst & ((m1_w & w_sel) | (m1_r & r_sel));
    assign ram_w_en = w_go;
    assign ram_w_addr = w_sel ? m1_addr : m0_addr;
    assign ram_w_data = w_sel ? m1_wdata : m0_wdata;
    assign ram_r_en = r_go;
    assign ram_r_addr = r_sel ? m1_addr : m0_addr;
    assign m0_rvalid = rsp_v & ~rsp_id;
    assign m1_rvalid = rsp_v & rsp_id;
    assign m0_rdata = m0_rvalid ? ram_r_data : '0;
    assign m1_rdata = m1_rvalid ? ram_r_data : '0;
    // remember each channel's last winner and tag the read in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_last <= 1'b1;
            rd_last <= 1'b1;
            rsp_v   <= 1'b0;
            rsp_id  <= 1'b0;
        end else begin
            if (w_go) wr_last <= w_sel;
            if (r_go) rd_last <= r_sel;
            if (r_go) rsp_id <= r_sel;
            rsp_v <= r_go;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter with a behavioural dual-port RAM
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 12;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_w_en, ram_r_en;
    logic [DW-1:0] m0_rdata, m1_rdata, ram_w_data;
    logic [DW-1:0] ram_r_data = '0;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    logic [DW:0] q[$];
    int checks = 0;
    int errors = 0;
    int cnt0, cnt1;

    ram_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // behavioural RAM: registered read, write-first on same-address collision
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= (ram_w_en && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit id, input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    // negedge: check the response due this cycle, then record this cycle's grants
    task automatic sample();
        logic [DW:0] e;
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e[DW] ? "rvalid_m1" : "rvalid_m0", {m1_rvalid, m0_rvalid}, e[DW] ? 64'd2 : 64'd1);
            chk("rdata", e[DW] ? m1_rdata : m0_rdata, {32'd0, e[DW-1:0]});
            chk("rdata_other", e[DW] ? m0_rdata : m1_rdata, 64'd0);
        end else begin
            chk("no_rvalid", {m1_rvalid, m0_rvalid}, 64'd0);
        end
        if (m0_gnt && m0_we) exp_mem[m0_addr] = m0_wdata;
        if (m1_gnt && m1_we) exp_mem[m1_addr] = m1_wdata;
        if (m0_gnt && !m0_we) q.push_back({1'b0, exp_mem[m0_addr]});
        if (m1_gnt && !m1_we) q.push_back({1'b1, exp_mem[m1_addr]});
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'hC0DE0000 | i;
            exp_mem[i] = 32'hC0DE0000 | i;
        end
        mem[12'h010] = 32'hAAAA0000; exp_mem[12'h010] = 32'hAAAA0000;
        mem[12'h020] = 32'hBBBB0000; exp_mem[12'h020] = 32'hBBBB0000;

        // reset held with both masters requesting
        drv(0, 1, 1, 12'h100, 32'h11111111);
        drv(1, 1, 1, 12'h101, 32'h22222222);
        sample();
        chk("rst_gnt_w", {m1_gnt, m0_gnt, ram_w_en, ram_r_en}, 64'd0);
        edge_();
        drv(0, 1, 0, 12'h010, 0);
        drv(1, 1, 0, 12'h020, 0);
        sample();
        chk("rst_gnt_r", {m1_gnt, m0_gnt, ram_w_en, ram_r_en}, 64'd0);
        edge_();

        // release with both writing: master 0 first
        rst = 1'b1;
        drv(0, 1, 1, 12'h100, 32'h11111111);
        drv(1, 1, 1, 12'h101, 32'h22222222);
        sample();
        chk("first_w_gnt", {m1_gnt, m0_gnt}, 64'd1);
        chk("first_w_ram", {ram_w_en, ram_w_addr, ram_w_data}, {1'b1, 12'h100, 32'h11111111});
        edge_();
        drv(0, 0, 0, 0, 0);
        sample();
        chk("second_w_gnt", {m1_gnt, m0_gnt}, 64'd2);
        chk("second_w_ram", {ram_w_en, ram_w_addr, ram_w_data}, {1'b1, 12'h101, 32'h22222222});
        edge_();

        // read contention
        drv(0, 1, 0, 12'h010, 0);
        drv(1, 1, 0, 12'h020, 0);
        sample();
        chk("rc0_gnt", {m1_gnt, m0_gnt, ram_r_en, ram_w_en}, 64'b0110);
        chk("rc0_addr", ram_r_addr, 64'h010);
        edge_();
        drv(0, 0, 0, 0, 0);
        sample();
        chk("rc1_gnt", {m1_gnt, m0_gnt}, 64'd2);
        chk("rc1_addr", ram_r_addr, 64'h020);
        edge_();
        drv(1, 0, 0, 0, 0);
        sample();
        chk("idle_en", {ram_r_en, ram_w_en}, 64'd0);
        edge_();

        // parallel write and read of the same address
        drv(0, 1, 1, 12'h005, 32'h12345678);
        drv(1, 1, 0, 12'h005, 0);
        sample();
        chk("par_gnt", {m1_gnt, m0_gnt, ram_w_en, ram_r_en}, 64'hF);
        edge_();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        sample();
        chk("par_rsp_data", m1_rdata, 64'h12345678);
        edge_();

        // write fairness: wr_last is 0 now, so master 1 wins first
        cnt0 = 0; cnt1 = 0;
        drv(0, 1, 1, 12'h200, 32'hA0A0A0A0);
        drv(1, 1, 1, 12'h300, 32'hB0B0B0B0);
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("fair_alt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 64'd2 : 64'd1);
            cnt0 += int'(m0_gnt);
            cnt1 += int'(m1_gnt);
            edge_();
        end
        chk("fair_counts", {cnt0[31:0], cnt1[31:0]}, {32'd4, 32'd4});
        drv(0, 0, 0, 0, 0);
        drv(1, 1, 1, 12'h301, 32'hB1B1B1B1);
        sample();
        chk("solo_w1a", {m1_gnt, m0_gnt}, 64'd2);
        edge_();
        drv(1, 1, 1, 12'h302, 32'hB2B2B2B2);
        sample();
        chk("solo_w1b", {m1_gnt, m0_gnt, ram_w_en}, 64'b101);
        chk("solo_w1b_ram", {ram_w_addr, ram_w_data}, {12'h302, 32'hB2B2B2B2});
        edge_();

        // drive both last registers to 0, then reset mid-read
        drv(1, 0, 0, 0, 0);
        drv(0, 1, 1, 12'h400, 32'h44444444);
        sample();
        chk("pre_w0", {m1_gnt, m0_gnt}, 64'd1);
        edge_();
        drv(0, 1, 0, 12'h020, 0);
        sample();
        chk("pre_r0", {m1_gnt, m0_gnt}, 64'd1);
        edge_();
        drv(0, 1, 0, 12'h010, 0);
        sample();
        chk("mid_r0_gnt", {m1_gnt, m0_gnt}, 64'd1);
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_gnt", {m1_gnt, m0_gnt, ram_r_en, ram_w_en}, 64'd0);
        edge_();
        sample();
        edge_();
        rst = 1'b1;
        drv(0, 1, 0, 12'h010, 0);
        drv(1, 1, 0, 12'h020, 0);
        sample();
        chk("post_rst_rd", {m1_gnt, m0_gnt}, 64'd1);
        edge_();
        drv(0, 1, 1, 12'h500, 32'h55555555);
        drv(1, 1, 1, 12'h501, 32'h66666666);
        sample();
        chk("post_rst_wr", {m1_gnt, m0_gnt, ram_w_addr}, {2'b01, 12'h500});
        edge_();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        sample();
        edge_();

        // single-requester streaming
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 0, AW'(i), 0);
            sample();
            chk("stream_gnt", {m1_gnt, m0_gnt, ram_r_addr}, {2'b10, AW'(i)});
            edge_();
        end
        drv(1, 0, 0, 0, 0);
        sample();
        edge_();
        sample();
        chk("q_empty", q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
